// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    REM = 3'd4,
    AND = 3'd5,
    OR  = 3'd6,
    XOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Result returned for a divide/remainder by zero; sliced to DATA_W (<= 64).
  localparam logic [63:0] ALU_DIV_ZERO_RESULT = '1;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side signals of the ALU arbiter.
// Latency: n/a (wires only).
// Backpressure: requests held until req_ready_o pulse; responses never stall.
// Ports: req_* / rsp_* face the client engines, alu_* face the single ALU,
// busy_o is status. master = environment side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  import alu_pkg::*;

  logic [N_REQ-1:0]          req_valid_i;
  logic [N_REQ-1:0]          req_ready_o;
  logic [N_REQ*DATA_W-1:0]   req_opa_i;
  logic [N_REQ*DATA_W-1:0]   req_opb_i;
  logic [N_REQ*ALU_OP_W-1:0] req_op_i;
  logic [N_REQ-1:0]          rsp_valid_o;
  logic [DATA_W-1:0]         rsp_result_o;
  logic                      rsp_err_o;
  logic                      alu_valid_o;
  logic [DATA_W-1:0]         alu_opa_o;
  logic [DATA_W-1:0]         alu_opb_o;
  logic [ALU_OP_W-1:0]       alu_op_o;
  logic                      alu_ready_i;
  logic [DATA_W-1:0]         alu_result_i;
  logic                      busy_o;

  modport master (
    output req_valid_i, req_opa_i, req_opb_i, req_op_i, alu_ready_i, alu_result_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
           alu_valid_o, alu_opa_o, alu_opb_o, alu_op_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_opa_i, req_opb_i, req_op_i, alu_ready_i, alu_result_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
           alu_valid_o, alu_opa_o, alu_opb_o, alu_op_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is used.
// Ports: req (request vector), ptr (last winner), gnt (one-hot), gnt_idx (encoded).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int   cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    // Start one past the last winner so it ends with the lowest priority.
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        gnt_idx                = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters, one transaction at a time, round-robin.
// Latency: >=3 cycles per transaction (IDLE accept, ISSUE, RESP); div/rem-by-0 skips ISSUE.
// Backpressure: requests wait for req_ready_o; ALU stall bounded by TIMEOUT_CYC; responses never stall.
// Ports: clk_i, rst_i (async, active-high), bus (alu_arbiter_if.slave).
module alu_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);
  import alu_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic [N_REQ-1:0]  owner;        // one-hot requester of the transaction in flight
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  alu_op_e           op_q;
  logic [DATA_W-1:0] result_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [N_REQ-1:0]  req_ready_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic              alu_valid_q;
  logic              busy_q;

  logic [N_REQ-1:0]  gnt_oh;
  logic [IDX_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] new_opa;
  logic [DATA_W-1:0] new_opb;
  alu_op_e           new_op;
  logic              div_zero;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (bus.req_valid_i),
    .ptr     (ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign new_opa  = bus.req_opa_i[int'(gnt_idx)*DATA_W +: DATA_W];
  assign new_opb  = bus.req_opb_i[int'(gnt_idx)*DATA_W +: DATA_W];
  assign new_op   = alu_op_e'(bus.req_op_i[int'(gnt_idx)*ALU_OP_W +: ALU_OP_W]);
  assign div_zero = is_div_op(new_op) && (new_opb == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N_REQ-1);
      owner       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= ADD;
      result_q    <= '0;
      err_q       <= 1'b0;
      wait_cnt    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      alu_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req_valid_i) begin
            req_ready_q <= gnt_oh;
            owner       <= gnt_oh;
            ptr         <= gnt_idx;
            opa_q       <= new_opa;
            opb_q       <= new_opb;
            op_q        <= new_op;
            busy_q      <= 1'b1;
            if (div_zero) begin
              // Answer locally; the ALU never sees a zero divisor.
              result_q    <= ALU_DIV_ZERO_RESULT[DATA_W-1:0];
              err_q       <= 1'b1;
              rsp_valid_q <= gnt_oh;
              state       <= RESP;
            end else begin
              alu_valid_q <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.alu_ready_i) begin
            result_q    <= bus.alu_result_i;
            err_q       <= 1'b0;
            alu_valid_q <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid_q <= owner;
            state       <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC-1)) begin
            // ALU hung: give up after TIMEOUT_CYC issue cycles.
            result_q    <= '0;
            err_q       <= 1'b1;
            alu_valid_q <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid_q <= owner;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          alu_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_err_o    = err_q;
  assign bus.alu_valid_o  = alu_valid_q;
  assign bus.alu_opa_o    = opa_q;
  assign bus.alu_opb_o    = opb_q;
  assign bus.alu_op_o     = op_q;
  assign bus.busy_o       = busy_q;

endmodule
